patch_sum_collector: RTL and testbench

- Downstream of the patch row reducers, in the dram_clk domain.
- Takes the stream of completed row sums (sum_rdy count, sum, owner_reducer), already muxed to one stream by the reducer arbiter.
- Accumulates the contributions per patch slot until PATCH_SIZE rows have arrived.
- Pushes each finished patch total into a small output FIFO for the result writer, with valid/ready handshake.

---
 rtl/patch_sum_collector_if.sv | 31 +++
 rtl/patch_sum_collector.sv | 140 ++++++++++++++
 tb/tb_patch_sum_collector.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/patch_sum_collector_if.sv
// Row-sum input, arm control and patch-total output bundle of the patch sum collector.
// The collector side uses the slave modport; the reducer/writer side uses master.
interface patch_sum_collector_if #(
  parameter int FP_SIZE = 32,
  parameter int N_SLOT  = 4
);
  localparam int SLOT_W = $clog2(N_SLOT);

  logic              arm;
  logic [SLOT_W-1:0] arm_slot;
  logic              row_valid;
  logic              row_ready;
  logic [1:0]        row_cnt;
  logic [SLOT_W-1:0] row_owner;
  logic [FP_SIZE-1:0] row_sum;
  logic              out_valid;
  logic              out_ready;
  logic [SLOT_W-1:0] out_slot;
  logic [FP_SIZE-1:0] out_sum;
  logic [2:0]        err;

  modport master (
    output arm, arm_slot, row_valid, row_cnt, row_owner, row_sum, out_ready,
    input  row_ready, out_valid, out_slot, out_sum, err
  );

  modport slave (
    input  arm, arm_slot, row_valid, row_cnt, row_owner, row_sum, out_ready,
    output row_ready, out_valid, out_slot, out_sum, err
  );
endinterface

// File: rtl/patch_sum_collector.sv
// Collects per-slot row sums into patch totals and queues finished totals
// in a small output FIFO for the result writer.
module patch_sum_collector #(
  parameter int FP_SIZE    = 32,
  parameter int PATCH_SIZE = 6,
  parameter int N_SLOT     = 4,
  parameter int OUT_DEPTH  = 4
) (
  input logic                   dram_clk,
  input logic                   reset,
  patch_sum_collector_if.slave  bus
);
  localparam int SLOT_W   = $clog2(N_SLOT);
  localparam int REM_RAW  = $clog2(PATCH_SIZE + 1);
  localparam int REM_W    = (REM_RAW < 2) ? 2 : REM_RAW;
  localparam int PTR_W    = $clog2(OUT_DEPTH);
  localparam int CNT_W    = PTR_W + 1;

  typedef enum logic {
    SLOT_IDLE,
    SLOT_ACCUM
  } slot_state_t;

  slot_state_t        state_q  [N_SLOT];
  slot_state_t        state_d  [N_SLOT];
  logic [FP_SIZE-1:0] acc_q    [N_SLOT];
  logic [FP_SIZE-1:0] acc_d    [N_SLOT];
  logic [REM_W-1:0]   remain_q [N_SLOT];
  logic [REM_W-1:0]   remain_d [N_SLOT];
  logic [2:0]         err_q;
  logic [2:0]         err_d;

  logic               row_accept;
  logic [REM_W-1:0]   cnt_ext;
  logic               push;
  logic [SLOT_W-1:0]  push_slot;
  logic [FP_SIZE-1:0] push_sum;
  logic               pop;

  logic [SLOT_W-1:0]  fifo_slot [OUT_DEPTH];
  logic [FP_SIZE-1:0] fifo_sum  [OUT_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;

  // row_ready only looks at FIFO space, so a completing row always has room to push
  assign bus.row_ready = (count_q < CNT_W'(OUT_DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign bus.out_slot  = fifo_slot[rd_ptr_q];
  assign bus.out_sum   = fifo_sum[rd_ptr_q];
  assign bus.err       = err_q;

  assign row_accept = bus.row_valid && bus.row_ready;
  assign pop        = bus.out_valid && bus.out_ready;

  always_ff @(posedge dram_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_SLOT; i++) begin
        state_q[i]  <= SLOT_IDLE;
        acc_q[i]    <= '0;
        remain_q[i] <= '0;
      end
      err_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      remain_q <= remain_d;
      err_q    <= err_d;
    end
  end

  // Row is applied first; the arm then sees the post-row state, which lets a
  // completing slot re-arm in the same cycle without a rearm error.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    remain_d  = remain_q;
    err_d     = err_q;
    push      = 1'b0;
    push_slot = bus.row_owner;
    push_sum  = acc_q[bus.row_owner] + bus.row_sum;
    cnt_ext   = REM_W'(bus.row_cnt);

    if (row_accept && (bus.row_cnt != 2'd0)) begin
      if (state_q[bus.row_owner] == SLOT_ACCUM) begin
        if (cnt_ext < remain_q[bus.row_owner]) begin
          acc_d[bus.row_owner]    = push_sum;
          remain_d[bus.row_owner] = remain_q[bus.row_owner] - cnt_ext;
        end else begin
          push                    = 1'b1;
          state_d[bus.row_owner]  = SLOT_IDLE;
          acc_d[bus.row_owner]    = '0;
          remain_d[bus.row_owner] = '0;
          if (cnt_ext > remain_q[bus.row_owner]) begin
            err_d[2] = 1'b1;
          end
        end
      end else begin
        err_d[1] = 1'b1;
      end
    end

    if (bus.arm) begin
      if (state_d[bus.arm_slot] == SLOT_IDLE) begin
        state_d[bus.arm_slot]  = SLOT_ACCUM;
        acc_d[bus.arm_slot]    = '0;
        remain_d[bus.arm_slot] = REM_W'(PATCH_SIZE);
      end else begin
        err_d[0] = 1'b1;
      end
    end
  end

  // Output FIFO; pointers wrap naturally because OUT_DEPTH is a power of two
  always_ff @(posedge dram_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        fifo_slot[i] <= '0;
        fifo_sum[i]  <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_slot[wr_ptr_q] <= push_slot;
        fifo_sum[wr_ptr_q]  <= push_sum;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_patch_sum_collector.sv
// Directed bench for patch_sum_collector: inputs change and outputs are
// checked on the falling edge, away from the active rising edge.
module tb_patch_sum_collector;
  logic dram_clk;
  logic reset;
  int   compare_count;
  int   mismatch_count;

  patch_sum_collector_if bus ();

  patch_sum_collector dut (
    .dram_clk (dram_clk),
    .reset    (reset),
    .bus      (bus)
  );

  initial dram_clk = 1'b0;
  always #5 dram_clk = ~dram_clk;

  task automatic step();
    @(posedge dram_clk);
    @(negedge dram_clk);
  endtask

  task automatic applyStimulus(input logic do_arm, input logic [1:0] a_slot,
                               input logic valid, input logic [1:0] owner,
                               input logic [1:0] cnt, input logic [31:0] sum);
    bus.arm       = do_arm;
    bus.arm_slot  = a_slot;
    bus.row_valid = valid;
    bus.row_owner = owner;
    bus.row_cnt   = cnt;
    bus.row_sum   = sum;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 32'd0);
  endtask

  task automatic armSlot(input logic [1:0] s);
    applyStimulus(1'b1, s, 1'b0, 2'd0, 2'd0, 32'd0);
    step();
    idle();
  endtask

  task automatic sendRow(input logic [1:0] owner, input logic [1:0] cnt, input logic [31:0] sum);
    applyStimulus(1'b0, 2'd0, 1'b1, owner, cnt, sum);
    step();
    idle();
  endtask

  task automatic popHead();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compare_count++;
    assert (observed === expected)
    else begin
      mismatch_count++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkHead(input string tag, input logic [1:0] slot, input logic [31:0] sum);
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, "_slot"},  32'(bus.out_slot),  32'(slot));
    checkOutput({tag, "_sum"},   bus.out_sum,        sum);
  endtask

  // Three rows of cnt 2 complete a 6-row patch with total 3*base
  task automatic fullPatch(input logic [1:0] s, input logic [31:0] base);
    for (int i = 0; i < 3; i++) sendRow(s, 2'd2, base);
  endtask

  initial begin
    compare_count  = 0;
    mismatch_count = 0;
    reset          = 1'b1;
    bus.out_ready  = 1'b0;
    idle();
    repeat (2) @(negedge dram_clk);

    $display("[TB] reset state");
    checkOutput("rst_row_ready", 32'(bus.row_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_slot",  32'(bus.out_slot),  32'd0);
    checkOutput("rst_out_sum",   bus.out_sum,        32'd0);
    checkOutput("rst_err",       32'(bus.err),       32'd0);
    reset = 1'b0;
    step();

    $display("[TB] single patch on slot 2");
    armSlot(2'd2);
    sendRow(2'd2, 2'd2, 32'd10);
    sendRow(2'd2, 2'd2, 32'd20);
    applyStimulus(1'b0, 2'd0, 1'b1, 2'd2, 2'd2, 32'd30);
    checkOutput("single_pre_valid", 32'(bus.out_valid), 32'd0);
    step();
    idle();
    checkHead("single", 2'd2, 32'd60);
    popHead();
    checkOutput("single_drained", 32'(bus.out_valid), 32'd0);
    // Re-arming slot 2 without a rearm error shows it returned to IDLE
    armSlot(2'd2);
    checkOutput("single_idle_err", 32'(bus.err), 32'd0);

    $display("[TB] interleaved patches on slots 0 and 1");
    armSlot(2'd0);
    armSlot(2'd1);
    for (int i = 0; i < 6; i++) begin
      sendRow(2'd0, 2'd1, 32'd1);
      if (i < 3) sendRow(2'd1, 2'd2, 32'd100);
    end
    checkHead("inter_first", 2'd1, 32'd300);
    popHead();
    checkHead("inter_second", 2'd0, 32'd6);
    popHead();
    checkOutput("inter_empty", 32'(bus.out_valid), 32'd0);
    checkOutput("inter_err",   32'(bus.err),       32'd0);

    $display("[TB] backpressure");
    fullPatch(2'd2, 32'd7);
    armSlot(2'd0);
    fullPatch(2'd0, 32'd11);
    armSlot(2'd1);
    fullPatch(2'd1, 32'd13);
    armSlot(2'd3);
    checkOutput("bp_ready_before_4th", 32'(bus.row_ready), 32'd1);
    fullPatch(2'd3, 32'd17);
    checkOutput("bp_ready_full", 32'(bus.row_ready), 32'd0);
    checkHead("bp_head_full", 2'd2, 32'd21);
    armSlot(2'd0);
    checkOutput("bp_arm_while_full_err", 32'(bus.err), 32'd0);
    applyStimulus(1'b0, 2'd0, 1'b1, 2'd0, 2'd2, 32'd100);
    step();
    step();
    checkOutput("bp_still_full", 32'(bus.row_ready), 32'd0);
    checkHead("bp_head_held", 2'd2, 32'd21);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    checkOutput("bp_ready_after_pop", 32'(bus.row_ready), 32'd1);
    checkHead("bp_head_after_pop", 2'd0, 32'd33);
    step();
    idle();
    checkOutput("bp_ready_after_held", 32'(bus.row_ready), 32'd1);
    sendRow(2'd0, 2'd2, 32'd200);
    sendRow(2'd0, 2'd2, 32'd300);
    checkOutput("bp_full_again", 32'(bus.row_ready), 32'd0);
    checkHead("bp_order_0", 2'd0, 32'd33);
    popHead();
    checkHead("bp_order_1", 2'd1, 32'd39);
    popHead();
    checkHead("bp_order_2", 2'd3, 32'd51);
    popHead();
    checkHead("bp_order_3", 2'd0, 32'd600);
    popHead();
    checkOutput("bp_drained", 32'(bus.out_valid), 32'd0);
    checkOutput("bp_err",     32'(bus.err),       32'd0);

    $display("[TB] same-cycle arm and completion on slot 0");
    armSlot(2'd0);
    sendRow(2'd0, 2'd2, 32'd1);
    sendRow(2'd0, 2'd2, 32'd2);
    applyStimulus(1'b1, 2'd0, 1'b1, 2'd0, 2'd2, 32'd3);
    step();
    idle();
    checkHead("rearm_total", 2'd0, 32'd6);
    checkOutput("rearm_err", 32'(bus.err), 32'd0);
    popHead();
    fullPatch(2'd0, 32'd5);
    checkHead("rearm_next", 2'd0, 32'd15);
    checkOutput("rearm_next_err", 32'(bus.err), 32'd0);
    popHead();
    sendRow(2'd3, 2'd0, 32'd99);
    checkOutput("cnt0_err",   32'(bus.err),       32'd0);
    checkOutput("cnt0_valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] error flags");
    sendRow(2'd3, 2'd2, 32'd9);
    checkOutput("unarmed_err",   32'(bus.err),       32'd2);
    checkOutput("unarmed_valid", 32'(bus.out_valid), 32'd0);
    armSlot(2'd1);
    sendRow(2'd1, 2'd2, 32'd40);
    armSlot(2'd1);
    checkOutput("rearm_active_err", 32'(bus.err), 32'd3);
    sendRow(2'd1, 2'd2, 32'd2);
    sendRow(2'd1, 2'd2, 32'd3);
    checkHead("partial_kept", 2'd1, 32'd45);
    popHead();
    armSlot(2'd1);
    sendRow(2'd1, 2'd2, 32'd1);
    sendRow(2'd1, 2'd2, 32'd1);
    sendRow(2'd1, 2'd1, 32'd1);
    checkOutput("overrun_pre_err", 32'(bus.err), 32'd3);
    sendRow(2'd1, 2'd2, 32'd10);
    checkHead("overrun_total", 2'd1, 32'd13);
    checkOutput("overrun_err", 32'(bus.err), 32'd7);
    popHead();

    $display("[TB] asynchronous reset mid-operation");
    armSlot(2'd2);
    sendRow(2'd2, 2'd2, 32'd9);
    armSlot(2'd3);
    fullPatch(2'd3, 32'd1);
    checkHead("pre_reset_head", 2'd3, 32'd3);
    reset = 1'b1;
    #1;
    checkOutput("async_rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("async_rst_err",   32'(bus.err),       32'd0);
    checkOutput("async_rst_ready", 32'(bus.row_ready), 32'd1);
    @(negedge dram_clk);
    reset = 1'b0;
    sendRow(2'd2, 2'd2, 32'd1);
    checkOutput("post_rst_unarmed_err", 32'(bus.err),       32'd2);
    checkOutput("post_rst_valid",       32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end
endmodule
